axi_lite_mem_arbiter: RTL and testbench

//  Shares one AXI4-Lite BRAM slave (dual-port BRAM controller behind axi_mem) between two AXI4-Lite

---
 rtl/axi_lite_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master AXI4-Lite arbiter in front of a single BRAM slave.
// Round-robin grant with one transaction in flight; no new grant is issued while the BRAM reports reset-busy.
//
// state    | meaning
// IDLE     | no grant; arbitrate when memory is not busy
// RD_ADDR  | forward AR of granted master
// RD_DATA  | return R to granted master
// WR_REQ   | forward AW and W independently
// WR_RESP  | return B to granted master
module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         mem_busy_i,
    input  logic [1:0][ADDR_W-1:0]       m_aw_addr_i,
    input  logic [1:0]                   m_aw_valid_i,
    output logic [1:0]                   m_aw_ready_o,
    input  logic [1:0][DATA_W-1:0]       m_w_data_i,
    input  logic [1:0][DATA_W/8-1:0]     m_w_strb_i,
    input  logic [1:0]                   m_w_valid_i,
    output logic [1:0]                   m_w_ready_o,
    output logic [1:0][1:0]              m_b_resp_o,
    output logic [1:0]                   m_b_valid_o,
    input  logic [1:0]                   m_b_ready_i,
    input  logic [1:0][ADDR_W-1:0]       m_ar_addr_i,
    input  logic [1:0]                   m_ar_valid_i,
    output logic [1:0]                   m_ar_ready_o,
    output logic [1:0][DATA_W-1:0]       m_r_data_o,
    output logic [1:0][1:0]              m_r_resp_o,
    output logic [1:0]                   m_r_valid_o,
    input  logic [1:0]                   m_r_ready_i,
    output logic [ADDR_W-1:0]            s_aw_addr_o,
    output logic                         s_aw_valid_o,
    input  logic                         s_aw_ready_i,
    output logic [DATA_W-1:0]            s_w_data_o,
    output logic [DATA_W/8-1:0]          s_w_strb_o,
    output logic                         s_w_valid_o,
    input  logic                         s_w_ready_i,
    input  logic [1:0]                   s_b_resp_i,
    input  logic                         s_b_valid_i,
    output logic                         s_b_ready_o,
    output logic [ADDR_W-1:0]            s_ar_addr_o,
    output logic                         s_ar_valid_o,
    input  logic                         s_ar_ready_i,
    input  logic [DATA_W-1:0]            s_r_data_i,
    input  logic [1:0]                   s_r_resp_i,
    input  logic                         s_r_valid_i,
    output logic                         s_r_ready_o
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t     state;
    logic       gnt;
    logic       last_gnt;
    logic       aw_done;
    logic       w_done;
    logic [1:0] req;
    logic       win;
    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign req = m_ar_valid_i | m_aw_valid_i;
    // On a tie the master that did not win last time goes first.
    assign win = (req[0] & req[1]) ? ~last_gnt : req[1];

    assign ar_hs = s_ar_valid_o & s_ar_ready_i;
    assign r_hs  = s_r_valid_i  & s_r_ready_o;
    assign aw_hs = s_aw_valid_o & s_aw_ready_i;
    assign w_hs  = s_w_valid_o  & s_w_ready_i;
    assign b_hs  = s_b_valid_i  & s_b_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mem_busy_i && (|req)) begin
                        gnt      <= win;
                        last_gnt <= win;
                        state    <= m_ar_valid_i[win] ? RD_ADDR : WR_REQ;
                    end
                end
                RD_ADDR: if (ar_hs) state <= RD_DATA;
                RD_DATA: if (r_hs)  state <= IDLE;
                WR_REQ: begin
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        state   <= WR_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                WR_RESP: if (b_hs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is routed from state/gnt only, so one master's valid never reaches the other's ready.
    always_comb begin
        m_aw_ready_o = '0;
        m_w_ready_o  = '0;
        m_b_resp_o   = '0;
        m_b_valid_o  = '0;
        m_ar_ready_o = '0;
        m_r_data_o   = '0;
        m_r_resp_o   = '0;
        m_r_valid_o  = '0;
        s_aw_addr_o  = '0;
        s_aw_valid_o = 1'b0;
        s_w_data_o   = '0;
        s_w_strb_o   = '0;
        s_w_valid_o  = 1'b0;
        s_b_ready_o  = 1'b0;
        s_ar_addr_o  = '0;
        s_ar_valid_o = 1'b0;
        s_r_ready_o  = 1'b0;
        case (state)
            RD_ADDR: begin
                s_ar_addr_o       = m_ar_addr_i[gnt];
                s_ar_valid_o      = m_ar_valid_i[gnt];
                m_ar_ready_o[gnt] = s_ar_ready_i;
            end
            RD_DATA: begin
                m_r_data_o[gnt]  = s_r_data_i;
                m_r_resp_o[gnt]  = s_r_resp_i;
                m_r_valid_o[gnt] = s_r_valid_i;
                s_r_ready_o      = m_r_ready_i[gnt];
            end
            WR_REQ: begin
                s_aw_addr_o       = m_aw_addr_i[gnt];
                s_aw_valid_o      = m_aw_valid_i[gnt] & ~aw_done;
                m_aw_ready_o[gnt] = s_aw_ready_i & ~aw_done;
                s_w_data_o        = m_w_data_i[gnt];
                s_w_strb_o        = m_w_strb_i[gnt];
                s_w_valid_o       = m_w_valid_i[gnt] & ~w_done;
                m_w_ready_o[gnt]  = s_w_ready_i & ~w_done;
            end
            WR_RESP: begin
                m_b_resp_o[gnt]  = s_b_resp_i;
                m_b_valid_o[gnt] = s_b_valid_i;
                s_b_ready_o      = m_b_ready_i[gnt];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter with a small behavioural BRAM slave.
module tb_axi_lite_mem_arbiter;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 mem_busy_i = 1'b0;
    logic [1:0][31:0]     m_aw_addr_i = '0;
    logic [1:0]           m_aw_valid_i = '0;
    logic [1:0]           m_aw_ready_o;
    logic [1:0][31:0]     m_w_data_i = '0;
    logic [1:0][3:0]      m_w_strb_i = '0;
    logic [1:0]           m_w_valid_i = '0;
    logic [1:0]           m_w_ready_o;
    logic [1:0][1:0]      m_b_resp_o;
    logic [1:0]           m_b_valid_o;
    logic [1:0]           m_b_ready_i = '0;
    logic [1:0][31:0]     m_ar_addr_i = '0;
    logic [1:0]           m_ar_valid_i = '0;
    logic [1:0]           m_ar_ready_o;
    logic [1:0][31:0]     m_r_data_o;
    logic [1:0][1:0]      m_r_resp_o;
    logic [1:0]           m_r_valid_o;
    logic [1:0]           m_r_ready_i = '0;
    logic [31:0]          s_aw_addr_o;
    logic                 s_aw_valid_o;
    logic                 s_aw_ready_i;
    logic [31:0]          s_w_data_o;
    logic [3:0]           s_w_strb_o;
    logic                 s_w_valid_o;
    logic                 s_w_ready_i;
    logic [1:0]           s_b_resp_i;
    logic                 s_b_valid_i;
    logic                 s_b_ready_o;
    logic [31:0]          s_ar_addr_o;
    logic                 s_ar_valid_o;
    logic                 s_ar_ready_i;
    logic [31:0]          s_r_data_i;
    logic [1:0]           s_r_resp_i;
    logic                 s_r_valid_i;
    logic                 s_r_ready_o;

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_busy_i(mem_busy_i),
        .m_aw_addr_i(m_aw_addr_i), .m_aw_valid_i(m_aw_valid_i), .m_aw_ready_o(m_aw_ready_o),
        .m_w_data_i(m_w_data_i), .m_w_strb_i(m_w_strb_i), .m_w_valid_i(m_w_valid_i),
        .m_w_ready_o(m_w_ready_o),
        .m_b_resp_o(m_b_resp_o), .m_b_valid_o(m_b_valid_o), .m_b_ready_i(m_b_ready_i),
        .m_ar_addr_i(m_ar_addr_i), .m_ar_valid_i(m_ar_valid_i), .m_ar_ready_o(m_ar_ready_o),
        .m_r_data_o(m_r_data_o), .m_r_resp_o(m_r_resp_o), .m_r_valid_o(m_r_valid_o),
        .m_r_ready_i(m_r_ready_i),
        .s_aw_addr_o(s_aw_addr_o), .s_aw_valid_o(s_aw_valid_o), .s_aw_ready_i(s_aw_ready_i),
        .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o), .s_w_valid_o(s_w_valid_o),
        .s_w_ready_i(s_w_ready_i),
        .s_b_resp_i(s_b_resp_i), .s_b_valid_i(s_b_valid_i), .s_b_ready_o(s_b_ready_o),
        .s_ar_addr_o(s_ar_addr_o), .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i),
        .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i), .s_r_valid_i(s_r_valid_i),
        .s_r_ready_o(s_r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // behavioural slave: word k holds C0FFEE_kk, 0x100 holds DEADBEEF, reads of 0x8 answer SLVERR
    logic [31:0] mem [0:255];
    logic [31:0] rd_addr_q, wa_q, wd_q;
    logic [3:0]  ws_q;
    logic        r_pend, aw_got, w_got;
    logic        aw_hold = 1'b0;
    logic        r_hold  = 1'b0;

    assign s_ar_ready_i = 1'b1;
    assign s_w_ready_i  = 1'b1;
    assign s_aw_ready_i = !aw_hold || w_got;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 256; k++) mem[k] <= {24'hC0FFEE, k[7:0]};
            mem[8'h40]  <= 32'hDEAD_BEEF;
            rd_addr_q   <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            ws_q        <= '0;
            r_pend      <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            s_r_valid_i <= 1'b0;
            s_r_data_i  <= '0;
            s_r_resp_i  <= '0;
            s_b_valid_i <= 1'b0;
            s_b_resp_i  <= '0;
        end else begin
            if (s_ar_valid_o && s_ar_ready_i) begin
                rd_addr_q <= s_ar_addr_o;
                r_pend    <= 1'b1;
            end
            if (r_pend && !r_hold && !s_r_valid_i) begin
                s_r_valid_i <= 1'b1;
                s_r_data_i  <= mem[rd_addr_q[9:2]];
                s_r_resp_i  <= (rd_addr_q == 32'h8) ? 2'b10 : 2'b00;
                r_pend      <= 1'b0;
            end else if (s_r_valid_i && s_r_ready_o) begin
                s_r_valid_i <= 1'b0;
            end
            if (s_aw_valid_o && s_aw_ready_i) begin
                aw_got <= 1'b1;
                wa_q   <= s_aw_addr_o;
            end
            if (s_w_valid_o && s_w_ready_i) begin
                w_got <= 1'b1;
                wd_q  <= s_w_data_o;
                ws_q  <= s_w_strb_o;
            end
            if (aw_got && w_got && !s_b_valid_i) begin
                for (int b = 0; b < 4; b++)
                    if (ws_q[b]) mem[wa_q[9:2]][b*8 +: 8] <= wd_q[b*8 +: 8];
                s_b_valid_i <= 1'b1;
                s_b_resp_i  <= 2'b00;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
            end else if (s_b_valid_i && s_b_ready_o) begin
                s_b_valid_i <= 1'b0;
            end
        end
    end

    // monitors
    int          cyc = 0;
    int          n_aw_hs = 0, n_w_hs = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, r_hs_cyc = 0;
    int          r_vld_cnt [2] = '{0, 0};
    int          b_cnt [2] = '{0, 0};
    logic [31:0] ar_log [$];

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!rst_i) begin
            if (s_ar_valid_o && s_ar_ready_i) ar_log.push_back(s_ar_addr_o);
            if (s_aw_valid_o && s_aw_ready_i) begin
                n_aw_hs   <= n_aw_hs + 1;
                aw_hs_cyc <= cyc;
            end
            if (s_w_valid_o && s_w_ready_i) begin
                n_w_hs   <= n_w_hs + 1;
                w_hs_cyc <= cyc;
            end
            if (s_r_valid_i && s_r_ready_o) r_hs_cyc <= cyc;
            for (int i = 0; i < 2; i++) begin
                if (m_r_valid_o[i]) r_vld_cnt[i] <= r_vld_cnt[i] + 1;
                if (m_b_valid_o[i] && m_b_ready_i[i]) b_cnt[i] <= b_cnt[i] + 1;
            end
        end
    end

    logic any_out;
    assign any_out = |{m_aw_ready_o, m_w_ready_o, m_b_resp_o, m_b_valid_o, m_ar_ready_o,
                       m_r_data_o, m_r_resp_o, m_r_valid_o, s_aw_addr_o, s_aw_valid_o,
                       s_w_data_o, s_w_strb_o, s_w_valid_o, s_b_ready_o, s_ar_addr_o,
                       s_ar_valid_o, s_r_ready_o};

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_rd(input int i, output logic [31:0] d, output logic [1:0] rs);
        int n;
        n = 0;
        while (!m_ar_ready_o[i] && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk($sformatf("ar_ready_timeout_m%0d", i), m_ar_ready_o[i], 1);
        @(posedge clk_i);
        #1;
        m_ar_valid_i[i] = 1'b0;
        m_r_ready_i[i]  = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!m_r_valid_o[i] && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk($sformatf("r_valid_timeout_m%0d", i), m_r_valid_o[i], 1);
        d  = m_r_data_o[i];
        rs = m_r_resp_o[i];
        @(posedge clk_i);
        #1;
        m_r_ready_i[i] = 1'b0;
    endtask

    task automatic rd(input int i, input logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] rs);
        @(negedge clk_i);
        m_ar_addr_i[i]  = a;
        m_ar_valid_i[i] = 1'b1;
        @(negedge clk_i);
        finish_rd(i, d, rs);
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int w_lead, output logic [1:0] br);
        int  c, n;
        logic afire, wfire;
        @(negedge clk_i);
        m_w_data_i[i]  = d;
        m_w_strb_i[i]  = s;
        m_w_valid_i[i] = 1'b1;
        m_aw_addr_i[i] = a;
        if (w_lead == 0) m_aw_valid_i[i] = 1'b1;
        c = 0;
        n = 0;
        while ((m_aw_valid_i[i] || m_w_valid_i[i] || c < w_lead) && n < 300) begin
            @(negedge clk_i);
            c++;
            n++;
            if (w_lead > 0 && c == w_lead) m_aw_valid_i[i] = 1'b1;
            afire = m_aw_valid_i[i] && m_aw_ready_o[i];
            wfire = m_w_valid_i[i] && m_w_ready_o[i];
            @(posedge clk_i);
            #1;
            if (afire) m_aw_valid_i[i] = 1'b0;
            if (wfire) m_w_valid_i[i] = 1'b0;
        end
        if (n >= 300) chk($sformatf("wr_req_timeout_m%0d", i), m_aw_valid_i[i] | m_w_valid_i[i], 0);
        m_b_ready_i[i] = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!m_b_valid_o[i] && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) chk($sformatf("b_valid_timeout_m%0d", i), m_b_valid_o[i], 1);
        br = m_b_resp_o[i];
        @(posedge clk_i);
        #1;
        m_b_ready_i[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] d0a, d0b, d1a, d1b, d;
        logic [1:0]  r0a, r0b, r1a, r1b, rs, br;
        int base, r1_before, aw_before, w_before, b0_before, b1_before, viol;

        // reset: outputs quiet even with master addresses driven
        m_ar_addr_i = {32'h1111_1111, 32'h2222_2222};
        m_aw_addr_i = {32'h3333_3333, 32'h4444_4444};
        repeat (3) @(negedge clk_i);
        chk("reset_outputs_zero", any_out, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("idle_outputs_zero", any_out, 0);

        // 2: both masters read back to back, alternating grants
        base = ar_log.size();
        fork
            begin rd(0, 32'h0, d0a, r0a); rd(0, 32'h8, d0b, r0b); end
            begin rd(1, 32'h4, d1a, r1a); rd(1, 32'hC, d1b, r1b); end
        join
        chk("t2_order0", ar_log[base],   32'h0);
        chk("t2_order1", ar_log[base+1], 32'h4);
        chk("t2_order2", ar_log[base+2], 32'h8);
        chk("t2_order3", ar_log[base+3], 32'hC);
        chk("t2_m0_data_a", d0a, 32'hC0FF_EE00);
        chk("t2_m0_data_b", d0b, 32'hC0FF_EE02);
        chk("t2_m0_resp_b", r0b, 2'b10);
        chk("t2_m1_data_a", d1a, 32'hC0FF_EE01);
        chk("t2_m1_data_b", d1b, 32'hC0FF_EE03);
        chk("t2_m1_resp_b", r1b, 2'b00);

        // 1: single read by m0, slave valid one cycle after the request
        r1_before = r_vld_cnt[1];
        @(negedge clk_i);
        m_ar_addr_i[0]  = 32'h0000_0100;
        m_ar_valid_i[0] = 1'b1;
        @(negedge clk_i);
        chk("t1_s_ar_valid", s_ar_valid_o, 1);
        chk("t1_s_ar_addr", s_ar_addr_o, 32'h100);
        finish_rd(0, d, rs);
        chk("t1_r_data", d, 32'hDEAD_BEEF);
        chk("t1_r_resp", rs, 2'b00);
        chk("t1_m1_r_valid_quiet", r_vld_cnt[1] - r1_before, 0);

        // 3: m1 presents W three cycles before AW; slave takes W first
        aw_before = n_aw_hs;
        w_before  = n_w_hs;
        b0_before = b_cnt[0];
        b1_before = b_cnt[1];
        aw_hold   = 1'b1;
        wr(1, 32'h40, 32'h1234_5678, 4'hF, 3, br);
        aw_hold   = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t3_aw_hs_count", n_aw_hs - aw_before, 1);
        chk("t3_w_hs_count", n_w_hs - w_before, 1);
        chk("t3_w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
        chk("t3_b_resp", br, 2'b00);
        chk("t3_b_count_m1", b_cnt[1] - b1_before, 1);
        chk("t3_b_count_m0", b_cnt[0] - b0_before, 0);
        chk("t3_mem_written", mem[8'h10], 32'h1234_5678);

        // 4: m0 read and write together, read first
        fork
            rd(0, 32'h10, d, rs);
            wr(0, 32'h20, 32'hA5A5_0F0F, 4'h3, 0, br);
        join
        repeat (2) @(negedge clk_i);
        chk("t4_r_data", d, 32'hC0FF_EE04);
        chk("t4_read_before_write", r_hs_cyc < aw_hs_cyc, 1);
        chk("t4_b_resp", br, 2'b00);
        chk("t4_mem_strobed", mem[8'h08], 32'hC0FF_0F0F);

        // 5: memory busy holds off the grant
        @(negedge clk_i);
        mem_busy_i      = 1'b1;
        m_ar_addr_i[0]  = 32'hC;
        m_ar_valid_i[0] = 1'b1;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (s_ar_valid_o || s_aw_valid_o || s_w_valid_o) viol++;
        end
        chk("t5_no_valid_while_busy", viol, 0);
        mem_busy_i = 1'b0;
        @(negedge clk_i);
        chk("t5_ar_valid_after_busy", s_ar_valid_o, 1);
        finish_rd(0, d, rs);
        chk("t5_r_data", d, 32'hC0FF_EE03);

        // 6: reset while m0 waits for read data
        r_hold = 1'b1;
        @(negedge clk_i);
        m_ar_addr_i[0]  = 32'h0;
        m_ar_valid_i[0] = 1'b1;
        @(negedge clk_i);
        while (!m_ar_ready_o[0] && viol < 200) begin
            @(negedge clk_i);
            viol++;
        end
        @(posedge clk_i);
        #1;
        m_ar_valid_i[0] = 1'b0;
        m_r_ready_i[0]  = 1'b1;
        @(negedge clk_i);
        chk("t6_in_rd_data", s_r_ready_o, 1);
        rst_i = 1'b1;
        #1;
        chk("t6_outputs_zero_at_reset", any_out, 0);
        repeat (2) @(negedge clk_i);
        chk("t6_outputs_zero_in_reset", any_out, 0);
        m_r_ready_i[0] = 1'b0;
        r_hold = 1'b0;
        rst_i  = 1'b0;
        base = ar_log.size();
        fork
            rd(0, 32'h4, d0a, r0a);
            rd(1, 32'hC, d1a, r1a);
        join
        chk("t6_first_grant_m0", ar_log[base], 32'h4);
        chk("t6_m0_data", d0a, 32'hC0FF_EE01);
        chk("t6_m1_data", d1a, 32'hC0FF_EE03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
